// File: rtl/fib_timer_pkg.sv
// rtl/fib_timer_pkg.sv - shared types and constants for the Fibonacci/timer sequencer
// Purpose: state encodings, display mode codes, LED bit indices, default tick base
//          and the tick period helper used by the prescaler.
// Ports:   none (package)
package fib_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIB  = 2'd1,
    ST_TIM  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_FIB  = 2'b01;
  localparam logic [1:0] MODE_TIM  = 2'b10;

  localparam int LED_IDLE = 0;
  localparam int LED_FIB  = 1;
  localparam int LED_TIM  = 2;
  localparam int LED_DONE = 3;
  localparam int LED_REJ  = 4;
  localparam int LED_TICK = 5;

  // Must be >= 2 so a tick never lands in the clear cycle itself.
  localparam int TICK_BASE_DEFAULT = 8;

  // Tick period in clk cycles for a given rate code.
  function automatic int tick_period(int base, logic [2:0] code);
    return base * (int'(code) + 1);
  endfunction

endpackage

// File: rtl/fib_timer_ctrl_if.sv
// rtl/fib_timer_ctrl_if.sv - command and engine-control bundle for fib_timer_ctrl
// Purpose: groups the button commands, engine wrap flags, engine strobes, display
//          select, registered rate code and status LEDs.
// Ports (master drives / slave drives):
//   master: start_f, start_t, stop_f_t, update, prog[2:0], f_wrap, t_wrap
//   slave:  f_clr, t_clr, f_en, t_en, mode[1:0], prog_q[2:0], led[5:0]
interface fib_timer_ctrl_if;
  logic       start_f;
  logic       start_t;
  logic       stop_f_t;
  logic       update;
  logic [2:0] prog;
  logic       f_wrap;
  logic       t_wrap;
  logic       f_clr;
  logic       t_clr;
  logic       f_en;
  logic       t_en;
  logic [1:0] mode;
  logic [2:0] prog_q;
  logic [5:0] led;

  modport master (
    output start_f, start_t, stop_f_t, update, prog, f_wrap, t_wrap,
    input  f_clr, t_clr, f_en, t_en, mode, prog_q, led
  );

  modport slave (
    input  start_f, start_t, stop_f_t, update, prog, f_wrap, t_wrap,
    output f_clr, t_clr, f_en, t_en, mode, prog_q, led
  );
endinterface

// File: rtl/fib_timer_ctrl_tick_prescaler.sv
// rtl/fib_timer_ctrl_tick_prescaler.sv - programmable tick divider for the engines
// Purpose: counts 0..TICK_BASE*(prog_q+1)-1 while run is high and flags the last
//          count; the counter is held at 0 whenever run is low.
// Ports:
//   clk     in  system clock
//   rst     in  synchronous active-low reset
//   run     in  count enable; low forces the counter to 0
//   prog_q  in  registered rate code
//   tick    out high during the final count of each period (combinational)
module tick_prescaler
  import fib_timer_pkg::*;
#(
  parameter int TICK_BASE = TICK_BASE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [2:0] prog_q,
  output logic       tick
);

  localparam int CW = $clog2(TICK_BASE * 8);

  logic [CW-1:0] cnt;
  logic [CW-1:0] last;

  assign last = CW'(tick_period(TICK_BASE, prog_q) - 1);
  assign tick = run && (cnt == last);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!run || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/fib_timer_ctrl.sv
// rtl/fib_timer_ctrl.sv - command sequencer for the Fibonacci/timer display datapath
// Purpose: decodes start/stop/update commands into engine clear/advance strobes,
//          owns the rate code, selects the display source and drives status LEDs.
// Configuration: AUTO_RESTART_EN - when defined, an engine wrap re-clears the engine
//          and keeps running instead of returning to idle.
// Ports:
//   clk  in     system clock
//   rst  in     synchronous active-low reset
//   bus  slave  fib_timer_ctrl_if (commands and wrap flags in; strobes, mode,
//               prog_q and led out)
module fib_timer_ctrl
  import fib_timer_pkg::*;
#(
  parameter int TICK_BASE = TICK_BASE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  fib_timer_ctrl_if.slave  bus
);

`ifdef AUTO_RESTART_EN
  localparam bit AUTO_RESTART = 1'b1;
`else
  localparam bit AUTO_RESTART = 1'b0;
`endif

  state_t     state_q, state_d;
  logic       accept_f, accept_t, accept_upd, accept_any;
  logic       reject, stop_evt, wrap_evt, restart;
  logic       run, tick;

  logic       f_clr_q, t_clr_q, f_en_q, t_en_q;
  logic       f_clr_d, t_clr_d, f_en_d, t_en_d;
  logic       done_q, done_d, rej_q, rej_d, heart_q, heart_d;
  logic [2:0] prog_r, prog_d;
  logic [1:0] mode_o;
  logic [5:0] led_o;

  // An auto-restart wrap drops run for one edge so the period restarts from 0
  // in the clear cycle, exactly like a fresh start.
  assign restart = wrap_evt && AUTO_RESTART;
  assign run     = (state_q != ST_IDLE) && !restart;

  tick_prescaler #(.TICK_BASE(TICK_BASE)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .prog_q (prog_r),
    .tick   (tick)
  );

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      f_clr_q <= 1'b0;
      t_clr_q <= 1'b0;
      f_en_q  <= 1'b0;
      t_en_q  <= 1'b0;
      done_q  <= 1'b0;
      rej_q   <= 1'b0;
      heart_q <= 1'b0;
      prog_r  <= 3'd0;
    end else begin
      state_q <= state_d;
      f_clr_q <= f_clr_d;
      t_clr_q <= t_clr_d;
      f_en_q  <= f_en_d;
      t_en_q  <= t_en_d;
      done_q  <= done_d;
      rej_q   <= rej_d;
      heart_q <= heart_d;
      prog_r  <= prog_d;
    end
  end

  // Next-state decode; priority stop > start_f > start_t > update everywhere.
  always_comb begin
    state_d    = state_q;
    accept_f   = 1'b0;
    accept_t   = 1'b0;
    accept_upd = 1'b0;
    reject     = 1'b0;
    stop_evt   = 1'b0;
    wrap_evt   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // stop is a no-op here but still masks lower-priority commands.
        if (bus.stop_f_t) begin
          state_d = ST_IDLE;
        end else if (bus.start_f) begin
          state_d  = ST_FIB;
          accept_f = 1'b1;
        end else if (bus.start_t) begin
          state_d  = ST_TIM;
          accept_t = 1'b1;
        end else if (bus.update) begin
          accept_upd = 1'b1;
        end
      end
      ST_FIB, ST_TIM: begin
        if (bus.stop_f_t) begin
          state_d  = ST_IDLE;
          stop_evt = 1'b1;
        end else begin
          reject = bus.start_f || bus.start_t || bus.update;
          // Wrap only counts when the engine was actually advanced this cycle.
          if ((state_q == ST_FIB && f_en_q && bus.f_wrap) ||
              (state_q == ST_TIM && t_en_q && bus.t_wrap)) begin
            wrap_evt = 1'b1;
            state_d  = AUTO_RESTART ? state_q : ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: next values of the registered outputs plus state-derived
  // mode and one-hot state LEDs.
  always_comb begin
    accept_any = accept_f || accept_t || accept_upd;
    f_clr_d    = accept_f || (restart && state_q == ST_FIB);
    t_clr_d    = accept_t || (restart && state_q == ST_TIM);
    f_en_d     = tick && !stop_evt && (state_q == ST_FIB);
    t_en_d     = tick && !stop_evt && (state_q == ST_TIM);
    done_d     = accept_any ? 1'b0 : (wrap_evt ? 1'b1 : done_q);
    rej_d      = accept_any ? 1'b0 : (reject ? 1'b1 : rej_q);
    heart_d    = heart_q ^ (f_en_d || t_en_d);
    prog_d     = accept_upd ? bus.prog : prog_r;

    case (state_q)
      ST_FIB:  mode_o = MODE_FIB;
      ST_TIM:  mode_o = MODE_TIM;
      default: mode_o = MODE_IDLE;
    endcase

    led_o           = '0;
    led_o[LED_IDLE] = (state_q == ST_IDLE);
    led_o[LED_FIB]  = (state_q == ST_FIB);
    led_o[LED_TIM]  = (state_q == ST_TIM);
    led_o[LED_DONE] = done_q;
    led_o[LED_REJ]  = rej_q;
    led_o[LED_TICK] = heart_q;
  end

  assign bus.f_clr  = f_clr_q;
  assign bus.t_clr  = t_clr_q;
  assign bus.f_en   = f_en_q;
  assign bus.t_en   = t_en_q;
  assign bus.mode   = mode_o;
  assign bus.prog_q = prog_r;
  assign bus.led    = led_o;

endmodule

// File: tb/tb_fib_timer_ctrl.sv
// tb/tb_fib_timer_ctrl.sv - self-checking bench for fib_timer_ctrl
module tb_fib_timer_ctrl;

  localparam int TB_BASE = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fib_timer_ctrl_if bus ();

  fib_timer_ctrl #(.TICK_BASE(TB_BASE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int kind;
    int at;
  } ev_t;

  ev_t   exp_q[$];
  string names[4] = '{"f_clr", "t_clr", "f_en", "t_en"};

  // Strobe scoreboard: every strobe seen must match the head of the expected queue.
  always @(negedge clk) begin
    logic [3:0] s;
    ev_t        e;
    s = {bus.t_en, bus.f_en, bus.t_clr, bus.f_clr};
    for (int k = 0; k < 4; k++) begin
      if (s[k]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL strobe_unexpected: %s at cycle %0d, required none", names[k], cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.kind != k || e.at != cyc) begin
            errors++;
            $display("FAIL strobe_order: got %s at cycle %0d, required %s at cycle %0d",
                     names[k], cyc, names[e.kind], e.at);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_until(int t);
    while (cyc < t) step();
  endtask

  task automatic push(int k, int at);
    ev_t e;
    e.kind = k;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic clear_cmds();
    bus.start_f  = 1'b0;
    bus.start_t  = 1'b0;
    bus.stop_f_t = 1'b0;
    bus.update   = 1'b0;
  endtask

  task automatic test_reset();
    rst          = 1'b0;
    bus.start_f  = 1'b1;
    bus.start_t  = 1'b1;
    bus.stop_f_t = 1'b1;
    bus.update   = 1'b1;
    bus.prog     = 3'd7;
    bus.f_wrap   = 1'b0;
    bus.t_wrap   = 1'b0;
    repeat (3) step();
    checks++;
    if (bus.led !== 6'b000001) begin errors++; $display("FAIL reset_led: got %b, required 000001", bus.led); end
    checks++;
    if (bus.mode !== 2'b00) begin errors++; $display("FAIL reset_mode: got %b, required 00", bus.mode); end
    checks++;
    if (bus.prog_q !== 3'd0) begin errors++; $display("FAIL reset_prog_q: got %0d, required 0", bus.prog_q); end
    checks++;
    if ({bus.f_clr, bus.t_clr, bus.f_en, bus.t_en} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_strobes: got %b, required 0000", {bus.f_clr, bus.t_clr, bus.f_en, bus.t_en});
    end
    clear_cmds();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_fib_run();
    int c;
    bus.update = 1'b1;
    bus.prog   = 3'd3;
    step();
    bus.update = 1'b0;
    checks++;
    if (bus.prog_q !== 3'd3) begin errors++; $display("FAIL upd_prog_q: got %0d, required 3", bus.prog_q); end
    c = cyc + 1;
    push(0, c);
    push(2, c + 16);
    push(2, c + 32);
    push(2, c + 48);
    bus.start_f = 1'b1;
    step();
    bus.start_f = 1'b0;
    checks++;
    if (bus.mode !== 2'b01) begin errors++; $display("FAIL fib_mode: got %b, required 01", bus.mode); end
    checks++;
    if (bus.led !== 6'b000010) begin errors++; $display("FAIL fib_led: got %b, required 000010", bus.led); end
    run_until(c + 50);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL fib_missing: got %0d pending strobes, required 0", exp_q.size()); end
  endtask

  task automatic test_stop();
    bus.stop_f_t = 1'b1;
    step();
    bus.stop_f_t = 1'b0;
    checks++;
    if (bus.mode !== 2'b00) begin errors++; $display("FAIL stop_mode: got %b, required 00", bus.mode); end
    checks++;
    if (bus.led[2:0] !== 3'b001) begin errors++; $display("FAIL stop_led: got %b, required 001", bus.led[2:0]); end
    run_until(cyc + 40);
    checks++;
    if (bus.mode !== 2'b00) begin errors++; $display("FAIL stop_hold: got %b, required 00", bus.mode); end
  endtask

  task automatic test_tim_reject();
    int c;
    c = cyc + 1;
    push(1, c);
    bus.start_t = 1'b1;
    step();
    bus.start_t = 1'b0;
    checks++;
    if (bus.mode !== 2'b10) begin errors++; $display("FAIL tim_mode: got %b, required 10", bus.mode); end
    bus.update = 1'b1;
    bus.prog   = 3'd5;
    step();
    bus.update = 1'b0;
    checks++;
    if (bus.prog_q !== 3'd3) begin errors++; $display("FAIL rej_prog_q: got %0d, required 3", bus.prog_q); end
    checks++;
    if (bus.led[4] !== 1'b1) begin errors++; $display("FAIL rej_led4: got %b, required 1", bus.led[4]); end
    bus.stop_f_t = 1'b1;
    bus.start_f  = 1'b1;
    step();
    clear_cmds();
    checks++;
    if (bus.led[2:0] !== 3'b001 || bus.mode !== 2'b00) begin
      errors++;
      $display("FAIL stop_start: got led %b mode %b, required led 001 mode 00", bus.led[2:0], bus.mode);
    end
    checks++;
    if (bus.led[4] !== 1'b1) begin errors++; $display("FAIL stop_start_led4: got %b, required 1", bus.led[4]); end
    repeat (20) step();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL tim_missing: got %0d pending strobes, required 0", exp_q.size()); end
  endtask

  task automatic test_both_starts();
    int c;
    c = cyc + 1;
    push(0, c);
    bus.start_f = 1'b1;
    bus.start_t = 1'b1;
    step();
    clear_cmds();
    checks++;
    if (bus.mode !== 2'b01 || bus.led[4] !== 1'b0) begin
      errors++;
      $display("FAIL both_start: got mode %b led4 %b, required mode 01 led4 0", bus.mode, bus.led[4]);
    end
    bus.start_t = 1'b1;
    step();
    bus.start_t = 1'b0;
    checks++;
    if (bus.mode !== 2'b01 || bus.led[4] !== 1'b1) begin
      errors++;
      $display("FAIL start_in_fib: got mode %b led4 %b, required mode 01 led4 1", bus.mode, bus.led[4]);
    end
    bus.stop_f_t = 1'b1;
    step();
    bus.stop_f_t = 1'b0;
    repeat (5) step();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL both_missing: got %0d pending strobes, required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int   c;
    logic hb0;
    bus.update = 1'b1;
    bus.prog   = 3'd0;
    step();
    bus.update = 1'b0;
    checks++;
    if (bus.prog_q !== 3'd0) begin errors++; $display("FAIL fast_prog_q: got %0d, required 0", bus.prog_q); end
    hb0 = bus.led[5];
    c = cyc + 1;
    push(1, c);
    push(3, c + 4);
    push(3, c + 8);
    push(3, c + 12);
    bus.start_t = 1'b1;
    step();
    bus.start_t = 1'b0;
    run_until(c + 13);
    bus.stop_f_t = 1'b1;
    step();
    bus.stop_f_t = 1'b0;
    run_until(c + 30);
    checks++;
    if (bus.led[5] !== ~hb0) begin errors++; $display("FAIL heartbeat: got %b, required %b", bus.led[5], ~hb0); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL fast_missing: got %0d pending strobes, required 0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    int c;
    bus.update = 1'b1;
    bus.prog   = 3'd3;
    step();
    bus.update = 1'b0;
    c = cyc + 1;
    push(0, c);
    push(2, c + 16);
`ifdef AUTO_RESTART_EN
    push(0, c + 17);
    push(2, c + 33);
`endif
    bus.f_wrap  = 1'b1;
    bus.start_f = 1'b1;
    step();
    bus.start_f = 1'b0;
    run_until(c + 17);
    bus.f_wrap = 1'b0;
`ifdef AUTO_RESTART_EN
    checks++;
    if (bus.mode !== 2'b01) begin errors++; $display("FAIL wrap_restart_mode: got %b, required 01", bus.mode); end
    run_until(c + 34);
    bus.stop_f_t = 1'b1;
    step();
    bus.stop_f_t = 1'b0;
`else
    checks++;
    if (bus.mode !== 2'b00 || bus.led[2:0] !== 3'b001) begin
      errors++;
      $display("FAIL wrap_idle: got mode %b led %b, required mode 00 led 001", bus.mode, bus.led[2:0]);
    end
`endif
    checks++;
    if (bus.led[3] !== 1'b1) begin errors++; $display("FAIL wrap_done: got %b, required 1", bus.led[3]); end
    repeat (5) step();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_missing: got %0d pending strobes, required 0", exp_q.size()); end
    bus.update = 1'b1;
    step();
    bus.update = 1'b0;
    checks++;
    if (bus.led[3] !== 1'b0) begin errors++; $display("FAIL done_clear: got %b, required 0", bus.led[3]); end
  endtask

  task automatic test_reset_midrun();
    int c;
    c = cyc + 1;
    push(1, c);
    bus.start_t = 1'b1;
    step();
    bus.start_t = 1'b0;
    repeat (5) step();
    rst = 1'b0;
    step();
    checks++;
    if (bus.led !== 6'b000001 || bus.mode !== 2'b00 || bus.prog_q !== 3'd0) begin
      errors++;
      $display("FAIL midrun_reset: got led %b mode %b prog_q %0d, required 000001 00 0",
               bus.led, bus.mode, bus.prog_q);
    end
    rst = 1'b1;
    repeat (20) step();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL midrun_missing: got %0d pending strobes, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_fib_run();
    test_stop();
    test_tim_reject();
    test_both_starts();
    test_back_to_back();
    test_wrap();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
